// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master among NREQ requesters; gnt one cycle after req is seen, done one cycle after the master returns to idle past stop.
// Requests are only sampled in ARB_IDLE and waiting ones simply hold req; I2C_ARB_TIMEOUT_EN adds a watchdog that force-completes with err.
module i2c_master_arbiter #(
    parameter int         NREQ    = 4,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rdata,
    output logic                busy,
    output logic                m_send_en,
    output logic                m_read,
    output logic                m_read_data,
    output logic [6:0]          m_addr,
    output logic [7:0]          m_wdata,
    input  logic [2:0]          m_state,
    input  logic                m_error,
    input  logic [7:0]          m_rdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_STOP = 3'd5;

    typedef enum logic [1:0] {ARB_IDLE, ARB_LAUNCH, ARB_WAIT, ARB_REPORT} arb_state_t;

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              rw_q, rw_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              send_q, send_d;
    logic              read_q, read_d;
    logic              rdir_q, rdir_d;
    logic              err_flag_q, err_flag_d;
    logic              seen_stop_q, seen_stop_d;

    logic [6:0]        addr_arr  [NREQ];
    logic [7:0]        wdata_arr [NREQ];
    logic              sel_vld;
    logic [IW-1:0]     sel_idx;
    logic [NREQ-1:0]   sel_oh, idx_oh;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[7*g+6:7*g];
        assign wdata_arr[g] = req_wdata[8*g+7:8*g];
    end

    assign sel_oh = NREQ'(1) << sel_idx;
    assign idx_oh = NREQ'(1) << idx_q;

    // Search starts just past the last served requester, so nobody is served twice before the rest.
    always_comb begin
        int            j;
        logic [IW-1:0] cand;
        j       = 0;
        cand    = '0;
        sel_vld = 1'b0;
        sel_idx = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last_q) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = IW'(j);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        send_d      = 1'b0;
        read_d      = 1'b0;
        rdir_d      = rdir_q;
        err_flag_d  = err_flag_q;
        seen_stop_d = seen_stop_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_vld) begin
                    state_d = ARB_LAUNCH;
                    idx_d   = sel_idx;
                    rw_d    = req_rw[sel_idx];
                    addr_d  = addr_arr[sel_idx];
                    wdata_d = wdata_arr[sel_idx];
                    gnt_d   = sel_oh;
                    busy_d  = 1'b1;
                    rdir_d  = req_rw[sel_idx];
                    read_d  = req_rw[sel_idx];
                    send_d  = ~req_rw[sel_idx];
                end
            end
            ARB_LAUNCH: begin
                // Exactly one strobe stays high until the master leaves idle.
                if (m_state != M_IDLE) begin
                    state_d = ARB_WAIT;
                end else begin
                    read_d = rw_q;
                    send_d = ~rw_q;
                end
            end
            ARB_WAIT: begin
                err_flag_d = err_flag_q | m_error;
                if (m_state == M_STOP) seen_stop_d = 1'b1;
                if (m_state == M_IDLE && seen_stop_q) begin
                    state_d = ARB_REPORT;
                    done_d  = idx_oh;
                    err_d   = (err_flag_q | m_error) ? idx_oh : '0;
                    if (rw_q) rdata_d = m_rdata;
                end
            end
            ARB_REPORT: begin
                state_d     = ARB_IDLE;
                last_d      = idx_q;
                err_flag_d  = 1'b0;
                seen_stop_d = 1'b0;
                gnt_d       = '0;
                busy_d      = 1'b0;
                rdir_d      = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase

`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d = '0;
        if (state_q == ARB_LAUNCH || state_q == ARB_WAIT) begin
            if (cnt_q == TIMEOUT) begin
                state_d = ARB_REPORT;
                send_d  = 1'b0;
                read_d  = 1'b0;
                done_d  = idx_oh;
                err_d   = idx_oh;
                rdata_d = rdata_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            last_q      <= IW'(NREQ-1);
            idx_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            send_q      <= 1'b0;
            read_q      <= 1'b0;
            rdir_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            seen_stop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            send_q      <= send_d;
            read_q      <= read_d;
            rdir_q      <= rdir_d;
            err_flag_q  <= err_flag_d;
            seen_stop_q <= seen_stop_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk1) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign m_send_en   = send_q;
    assign m_read      = read_q;
    assign m_read_data = rdir_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: behavioural master model plus a done-report scoreboard.
module tb_i2c_master_arbiter;
    localparam int NREQ = 4;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [7:0] TO = 8'd20;
`else
    localparam logic [7:0] TO = 8'd255;
`endif

    logic        clk1 = 1'b0;
    logic        rst;
    logic [3:0]  req, req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rdata;
    logic        busy, m_send_en, m_read, m_read_data;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [2:0]  m_state = 3'd0;
    logic        m_error = 1'b0;
    logic [7:0]  m_rdata = 8'h00;

    int total = 0;
    int bad   = 0;
    bit stuck = 0, nack = 0, mst_reset = 0;

    typedef struct {
        int         idx;
        bit         e;
        logic [7:0] rd;
        logic [6:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    initial forever #5 clk1 = ~clk1;

    i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk1(clk1), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .busy(busy), .m_send_en(m_send_en), .m_read(m_read), .m_read_data(m_read_data),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_state(m_state), .m_error(m_error),
        .m_rdata(m_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push(int idx, bit e, logic [7:0] rd, logic [6:0] a, logic [7:0] d);
        exp_t x;
        x.idx = idx; x.e = e; x.rd = rd; x.a = a; x.d = d;
        sb.push_back(x);
    endfunction

    task automatic set_req(input int i, input bit rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i]          = rw;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic wait_dones(input int n, input int budget, output int cyc);
        int got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk1);
            cyc++;
            if (done != 0) got++;
        end
        chk("done_count", got, n);
    endtask

    // Master model: one state per cycle start,address,ack1,data,ack2,stop,idle once a strobe is seen.
    initial begin
        logic [2:0] seq [0:6];
        int  pos = 0;
        bit  s;
        seq[0] = 3'd1; seq[1] = 3'd3; seq[2] = 3'd2; seq[3] = 3'd6;
        seq[4] = 3'd7; seq[5] = 3'd5; seq[6] = 3'd0;
        forever begin
            @(negedge clk1);
            s = m_send_en ^ m_read;
            @(posedge clk1);
            #1;
            if (mst_reset) begin
                m_state = 3'd0; pos = 0;
            end else if (m_state == 3'd0) begin
                if (s) begin pos = 0; m_state = seq[0]; end
            end else if (!(stuck && m_state == 3'd6)) begin
                pos++;
                m_state = seq[pos];
            end
            m_error = nack && (m_state == 3'd5);
        end
    end

    // Scoreboard monitor.
    initial begin
        bit   prev_done = 0;
        exp_t e;
        forever begin
            @(negedge clk1);
            if (gnt != 0) chk("gnt_onehot", $countones(gnt), 1);
            if (prev_done) chk("gnt_gap_after_done", gnt, 0);
            prev_done = (done != 0);
            if (done != 0) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got %b want none", done);
                end else begin
                    e = sb.pop_front();
                    chk("done_vec", done, 4'b1 << e.idx);
                    chk("err_vec", err, e.e ? (4'b1 << e.idx) : 4'b0);
                    chk("rdata", rdata, e.rd);
                    chk("m_addr", m_addr, e.a);
                    chk("m_wdata", m_wdata, e.d);
                end
            end else if (err != 0) begin
                total++; bad++;
                $display("FAIL err_without_done: got %b want 0", err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int c, dc;
        rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk1);
        chk("reset_ctl", {gnt, done, err, busy, m_send_en, m_read, m_read_data}, 0);
        chk("reset_dat", {rdata, m_addr, m_wdata}, 0);
        rst = 1'b1;
        @(negedge clk1);

        // Single write from requester 0.
        set_req(0, 1'b0, 7'h50, 8'hA5); req = 4'b0001;
        push(0, 1'b0, 8'h00, 7'h50, 8'hA5);
        @(negedge clk1);
        chk("w_send_c1", m_send_en, 1); chk("w_gnt_c1", gnt, 4'b0001);
        chk("w_busy_c1", busy, 1); chk("w_read_c1", m_read, 0);
        req = 4'b0000;
        @(negedge clk1); chk("w_send_c2", m_send_en, 1);
        @(negedge clk1); chk("w_send_c3", m_send_en, 0);
        wait_dones(1, 40, c); chk("w_done_cycle", c, 6);
        repeat (2) @(negedge clk1);

        // Single read from requester 2.
        set_req(2, 1'b1, 7'h21, 8'h00); m_rdata = 8'h3C; req = 4'b0100;
        push(2, 1'b0, 8'h3C, 7'h21, 8'h00);
        @(negedge clk1);
        chk("r_read_c1", m_read, 1); chk("r_send_c1", m_send_en, 0);
        chk("r_dir_c1", m_read_data, 1); chk("r_gnt_c1", gnt, 4'b0100);
        req = 4'b0000;
        repeat (4) @(negedge clk1);
        chk("r_dir_wait", m_read_data, 1); chk("r_read_wait", m_read, 0);
        wait_dones(1, 40, c); chk("r_done_cycle", c, 4);
        @(negedge clk1);

        // NACK: error during stop on requester 1.
        set_req(1, 1'b0, 7'h33, 8'h5A); nack = 1; req = 4'b0010;
        push(1, 1'b1, 8'h3C, 7'h33, 8'h5A);
        @(negedge clk1); req = 4'b0000;
        wait_dones(1, 40, c);
        nack = 0;
        @(negedge clk1);

        // Pointer wrap after last=1: 0 first, then 1; err_flag cleared.
        set_req(0, 1'b0, 7'h44, 8'h11); req = 4'b0011;
        push(0, 1'b0, 8'h3C, 7'h44, 8'h11);
        push(1, 1'b0, 8'h3C, 7'h33, 8'h5A);
        wait_dones(2, 60, c); req = 4'b0000;
        @(negedge clk1);

        // Reset while waiting on the master.
        set_req(2, 1'b0, 7'h22, 8'h77); req = 4'b0100;
        @(negedge clk1); req = 4'b0000;
        repeat (3) @(negedge clk1);
        chk("rst_busy_before", busy, 1);
        rst = 1'b0; mst_reset = 1;
        @(negedge clk1);
        chk("rst_ctl", {gnt, done, err, busy, m_send_en, m_read, m_read_data}, 0);
        chk("rst_dat", {rdata, m_addr, m_wdata}, 0);
        rst = 1'b1;
        @(negedge clk1); mst_reset = 0;
        repeat (10) @(negedge clk1);

        // Contention from restored pointer: 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 7'h10 + 7'(i), 8'hA0 + 8'(i));
        push(0, 1'b0, 8'h00, 7'h10, 8'hA0);
        push(1, 1'b0, 8'h00, 7'h11, 8'hA1);
        push(2, 1'b0, 8'h00, 7'h12, 8'hA2);
        push(3, 1'b0, 8'h00, 7'h13, 8'hA3);
        push(0, 1'b0, 8'h00, 7'h10, 8'hA0);
        req = 4'b1111;
        wait_dones(5, 200, c); req = 4'b0000;
        repeat (3) @(negedge clk1);

        // Master stuck in data phase.
        stuck = 1;
        set_req(3, 1'b0, 7'h5F, 8'hEE); req = 4'b1000;
`ifdef I2C_ARB_TIMEOUT_EN
        push(3, 1'b1, 8'h00, 7'h5F, 8'hEE);
`endif
        @(negedge clk1); req = 4'b0000;
`ifdef I2C_ARB_TIMEOUT_EN
        dc = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk1);
            if (done != 0) begin dc = k; break; end
        end
        chk("to_done_cycle", dc, 22);
        @(negedge clk1); chk("to_busy_low", busy, 0);
`else
        repeat (60) @(negedge clk1);
        chk("nto_busy_held", busy, 1);
`endif
        rst = 1'b0; mst_reset = 1; stuck = 0;
        @(negedge clk1); rst = 1'b1;
        @(negedge clk1); mst_reset = 0;
        repeat (5) @(negedge clk1);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
